core_sequencer: RTL
===================

# core_sequencer

Multi-cycle control FSM for the RV32 core: sequences instruction fetch, decode, execute, data-memory access and writeback around the combinational instruction decoder. Consumes the decoder's 6-bit instruction class and the ALU branch flag. Drives the instruction/data memory request handshakes, register-file write, PC update and writeback-mux selects. Sits between the memories and the datapath as the single owner of all architectural-state write enables.

## Interface

- `TIMEOUT`, default 255: max cycles a memory request may wait for ack; 0 disables the watchdog.
- `clk` in 1: core clock.
- `rst_n` in 1: synchronous, active-low reset.
- `run` in 1: enables fetching of new instructions.
- `instr` in 6: decoded instruction class from the decoder.
- `br_taken` in 1: ALU branch-condition result, valid in EXEC.
- `imem_req` out 1: instruction fetch request.
- `imem_ack` in 1: fetch data valid.
- `ir_we` out 1: latch instruction register.
- `dmem_req` out 1: data memory request.
- `dmem_we` out 1: store (1) / load (0).
- `dmem_ack` in 1: data access complete.
- `rf_we` out 1: register-file write.
- `wb_sel` out 2: 0 ALU, 1 memory, 2 PC+4, 3 immediate.
- `pc_we` out 1: PC update.
- `pc_sel` out 1: 0 PC+4, 1 PC+imm.
- `retired` out 1: one-cycle pulse per completed instruction.
- `instret` out 32: retired-instruction count.
- `halted` out 1: high in IDLE.
- `trap` out 1: sticky fault flag.
- `trap_cause` out 2: 0 none, 1 illegal, 2 imem timeout, 3 dmem timeout.
- `state` out 3: current FSM state, for debug.

## Operation

- Instruction classes: 0x00–0x09 R-ALU; 0x0A–0x12 I-ALU; 0x13–0x17 load; 0x18–0x1A store; 0x1B–0x1D, 0x20 branch; 0x21 JAL; 0x22 LUI; 0x23 AUIPC. All other codes, including 0x3F, are illegal.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- IDLE: `halted`=1. Goes to FETCH when `run`=1.
- FETCH: `imem_req` is held high until `imem_ack`. `ir_we`=1 in the ack cycle, then go to DECODE.
- DECODE: one cycle. Illegal class goes to TRAP with cause 1. Otherwise go to EXEC.
- EXEC: one cycle.
  - Branch: `pc_we`=1, `pc_sel`=`br_taken`, `retired`=1, then FETCH/IDLE.
  - Load/store: go to MEM.
  - Everything else: go to WB.
- MEM: `dmem_req` is held high until `dmem_ack`; `dmem_we`=1 for store classes.
  - Load ack: go to WB.
  - Store ack: `pc_we`=1, `pc_sel`=0, `retired`=1, then FETCH/IDLE.
- WB: `rf_we`=1, `pc_we`=1, `retired`=1, then FETCH/IDLE. Selects by class:
  - ALU: `wb_sel`=0, `pc_sel`=0.
  - Load: `wb_sel`=1, `pc_sel`=0.
  - JAL: `wb_sel`=2, `pc_sel`=1.
  - LUI: `wb_sel`=3, `pc_sel`=0.
  - AUIPC: `wb_sel`=0 (ALU computes PC+imm), `pc_sel`=0.
- Instruction boundary (the FETCH/IDLE choice above): next state is FETCH if `run`=1, else IDLE. Deasserting `run` never aborts an instruction in flight.
- Watchdog: counts cycles with a request high and no ack. When the count reaches `TIMEOUT`, the request drops and the FSM enters TRAP with cause 2 or 3.
- TRAP: absorbing until reset. `trap`=1, all enables 0.
- Write enables are otherwise 0; `wb_sel`/`pc_sel` are 0 when not in use.
- `instret` increments on each `retired` and wraps 0xFFFFFFFF to 0.

## Timing

- Outputs are Moore, decoded from registered state. The exception is `ir_we`, which is gated combinationally by `imem_ack`.
- Reset values: state IDLE, `halted`=1, `instret`=0, `trap`=0, `trap_cause`=0; all other outputs 0.
- Reset mid-handshake: requests are low in the cycle after the `rst_n`-low edge.
- Latency with ack in the same cycle as the request:
  - Branch: 3 cycles.
  - ALU/LUI/AUIPC/JAL: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
  - Each ack-wait cycle adds one.
- Ack arriving in the same cycle as a watchdog expiry counts as an ack; no trap is taken.
- Acks received outside their request state are ignored.
- `instret` updates on the edge after the `retired` pulse.

## Structure

- Shared package `core_pkg` holds:
  - Instruction-class localparams and range-check functions (`is_load`, `is_store`, `is_branch`, …).
  - State encoding.
  - `wb_sel`, `pc_sel` and `trap_cause` encodings.
- One sub-module, `ack_watchdog`: a cycle counter with `TIMEOUT` parameter, inputs `clear`/`count` and output `expired`. It is instantiated once and shared by both handshakes, since only one request is ever active at a time.

## Test plan

- Reset then `run`=1; ADD (0x00) with immediate acks → `rf_we`/`pc_we`/`retired` together in cycle 4; `instret`=1.
- Load (0x15) with `dmem_ack` delayed 3 cycles → `dmem_req` held 4 cycles, `dmem_we`=0, WB `wb_sel`=1; total latency 8.
- Branch 0x1B with `br_taken`=1, then again with 0 → EXEC `pc_sel`=1, then 0; `rf_we` never high.
- Illegal class 0x3F → TRAP, `trap_cause`=1, no `pc_we`; `rst_n` low clears it to IDLE.
- `TIMEOUT`=4, `imem_ack` never asserted → `imem_req` drops after 4 wait cycles, `trap_cause`=2. With `TIMEOUT`=0 the request persists indefinitely.
- `run` dropped during MEM of a store → store completes and retires, then IDLE with `halted`=1. `instret` preset near 0xFFFFFFFF wraps to 0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared encodings for the RV32 multi-cycle sequencer: states, instruction-class
// ranges, writeback/PC mux selects and trap causes.
package core_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  localparam logic [5:0] C_BR_EXT = 6'h20;
  localparam logic [5:0] C_JAL    = 6'h21;
  localparam logic [5:0] C_LUI    = 6'h22;
  localparam logic [5:0] C_AUIPC  = 6'h23;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  localparam logic PC_SEQ = 1'b0;
  localparam logic PC_REL = 1'b1;

  localparam logic [1:0] TC_NONE    = 2'd0;
  localparam logic [1:0] TC_ILLEGAL = 2'd1;
  localparam logic [1:0] TC_IMEM    = 2'd2;
  localparam logic [1:0] TC_DMEM    = 2'd3;

  function automatic logic is_alu(input logic [5:0] c);
    return c <= 6'h12;
  endfunction

  function automatic logic is_load(input logic [5:0] c);
    return (c >= 6'h13) && (c <= 6'h17);
  endfunction

  function automatic logic is_store(input logic [5:0] c);
    return (c >= 6'h18) && (c <= 6'h1A);
  endfunction

  function automatic logic is_branch(input logic [5:0] c);
    return ((c >= 6'h1B) && (c <= 6'h1D)) || (c == C_BR_EXT);
  endfunction

  function automatic logic is_legal(input logic [5:0] c);
    return is_alu(c) || is_load(c) || is_store(c) || is_branch(c) ||
           (c == C_JAL) || (c == C_LUI) || (c == C_AUIPC);
  endfunction

  function automatic logic [1:0] wb_sel_of(input logic [5:0] c);
    if (is_load(c))   return WB_MEM;
    if (c == C_JAL)   return WB_PC4;
    if (c == C_LUI)   return WB_IMM;
    return WB_ALU;
  endfunction

endpackage

// File: rtl/ack_watchdog.sv
// Wait-cycle counter shared by the fetch and data handshakes; expired fires in the
// TIMEOUT-th consecutive unacknowledged request cycle. TIMEOUT=0 never expires.
module ack_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = (TIMEOUT > 0) ? W'(TIMEOUT - 1) : '0;

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clear)
      r_cnt <= '0;
    else if (count && (r_cnt != LAST))
      r_cnt <= r_cnt + W'(1);
  end

  assign expired = (TIMEOUT != 0) && count && (r_cnt == LAST);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer; sole owner of the architectural
// write enables. Outputs decode the registered state; ir_we also follows imem_ack.
module core_sequencer
  import core_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [5:0]  instr,
  input  logic        br_taken,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        ir_we,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        retired,
  output logic [31:0] instret,
  output logic        halted,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [2:0]  state
);

  state_e      r_state;
  logic [5:0]  r_cls;
  logic [31:0] r_instret;
  logic [1:0]  r_cause;

  logic   w_req, w_ack, w_expired, w_retire;
  state_e w_bound;

  assign w_req   = (r_state == S_FETCH) || (r_state == S_MEM);
  assign w_ack   = ((r_state == S_FETCH) && imem_ack) || ((r_state == S_MEM) && dmem_ack);
  assign w_bound = run ? S_FETCH : S_IDLE;

  // Only one handshake is ever open, so one counter serves both.
  ack_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (!w_req || w_ack),
    .count   (w_req && !w_ack),
    .expired (w_expired)
  );

  assign w_retire = ((r_state == S_EXEC) && is_branch(r_cls)) ||
                    ((r_state == S_MEM) && is_store(r_cls) && dmem_ack) ||
                    (r_state == S_WB);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cls     <= '0;
      r_instret <= '0;
      r_cause   <= TC_NONE;
    end else begin
      if (w_retire) r_instret <= r_instret + 32'd1;
      case (r_state)
        S_IDLE:   if (run) r_state <= S_FETCH;
        S_FETCH: begin
          if (imem_ack) r_state <= S_DECODE;
          else if (w_expired) begin
            r_state <= S_TRAP;
            r_cause <= TC_IMEM;
          end
        end
        S_DECODE: begin
          r_cls <= instr;
          if (!is_legal(instr)) begin
            r_state <= S_TRAP;
            r_cause <= TC_ILLEGAL;
          end else
            r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (is_branch(r_cls))                        r_state <= w_bound;
          else if (is_load(r_cls) || is_store(r_cls)) r_state <= S_MEM;
          else                                         r_state <= S_WB;
        end
        S_MEM: begin
          if (dmem_ack) r_state <= is_store(r_cls) ? w_bound : S_WB;
          else if (w_expired) begin
            r_state <= S_TRAP;
            r_cause <= TC_DMEM;
          end
        end
        S_WB:     r_state <= w_bound;
        S_TRAP:   r_state <= S_TRAP;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = WB_ALU;
    pc_we    = 1'b0;
    pc_sel   = PC_SEQ;
    case (r_state)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ack;
      end
      S_EXEC: if (is_branch(r_cls)) begin
        pc_we  = 1'b1;
        pc_sel = br_taken;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store(r_cls);
        pc_we    = is_store(r_cls) && dmem_ack;
      end
      S_WB: begin
        rf_we  = 1'b1;
        pc_we  = 1'b1;
        wb_sel = wb_sel_of(r_cls);
        pc_sel = (r_cls == C_JAL) ? PC_REL : PC_SEQ;
      end
      default: ;
    endcase
  end

  assign retired    = w_retire;
  assign instret    = r_instret;
  assign halted     = (r_state == S_IDLE);
  assign trap       = (r_state == S_TRAP);
  assign trap_cause = r_cause;
  assign state      = r_state;

endmodule
